// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the Pong game-flow controller: state encoding and
// default game parameters.
package pong_game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } game_state_e;

    localparam int DEF_BALLS      = 3;
    localparam int DEF_BALL_W     = 2;
    localparam int DEF_HOLD_TICKS = 120;

endpackage

// File: rtl/pong_hold_timer.sv
// Pause timer counted in refresh ticks; start loads HOLD_TICKS-1 and the
// count runs down to zero on each tick. Idle/reset state is done.
module pong_hold_timer
    import pong_game_ctrl_pkg::*;
#(
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick,
    output logic done
);

    // HOLD_TICKS of 1 would give a zero-width counter, so keep at least one bit
    localparam int CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [CW-1:0] LOAD = CW'(HOLD_TICKS - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (start)
            count <= LOAD;
        else if (tick && count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM: tracks balls remaining, freezes graphics between balls,
// and drives the score counter's increment/clear inputs.
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int BALLS      = DEF_BALLS,
    parameter int BALL_W     = DEF_BALL_W,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        btn,
    input  logic              hit,
    input  logic              miss,
    input  logic              refr_tick,
    output logic              d_inc,
    output logic              d_clr,
    output logic              gra_still,
    output logic [BALL_W-1:0] ball_cnt,
    output logic [1:0]        state_o,
    output logic              game_over
);

    localparam logic [BALL_W-1:0] BALLS_V = BALL_W'(BALLS);

    game_state_e       state, state_nxt;
    logic [BALL_W-1:0] ball_nxt;
    logic              press;
    logic              timer_start;
    logic              timer_done;

    assign press = (btn != 2'b00);

    pong_hold_timer #(.HOLD_TICKS(HOLD_TICKS)) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .tick  (refr_tick),
        .done  (timer_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_NEWGAME;
            ball_cnt <= BALLS_V;
        end else begin
            state    <= state_nxt;
            ball_cnt <= ball_nxt;
        end
    end

    // A miss always wins over a simultaneous hit, and the last-ball miss
    // goes to OVER without decrementing so the count never wraps.
    always_comb begin
        state_nxt   = state;
        ball_nxt    = ball_cnt;
        timer_start = 1'b0;
        unique case (state)
            ST_NEWGAME: begin
                ball_nxt = BALLS_V;
                if (press) begin
                    state_nxt = ST_PLAY;
                    ball_nxt  = BALLS_V - 1'b1;
                end
            end
            ST_PLAY: begin
                if (miss) begin
                    timer_start = 1'b1;
                    if (ball_cnt == '0) begin
                        state_nxt = ST_OVER;
                    end else begin
                        state_nxt = ST_NEWBALL;
                        ball_nxt  = ball_cnt - 1'b1;
                    end
                end
            end
            ST_NEWBALL: begin
                if (timer_done && press)
                    state_nxt = ST_PLAY;
            end
            ST_OVER: begin
                if (timer_done) begin
                    state_nxt = ST_NEWGAME;
                    ball_nxt  = BALLS_V;
                end
            end
            default: state_nxt = ST_NEWGAME;
        endcase
    end

    always_comb begin
        d_clr     = (state == ST_NEWGAME);
        gra_still = (state != ST_PLAY);
        game_over = (state == ST_OVER);
        state_o   = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            d_inc <= 1'b0;
        else
            d_inc <= (state == ST_PLAY) && hit && !miss;
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a behavioural game model checked every
// cycle, plus literal expectations at key points of a full game.
module tb_pong_game_ctrl;

    localparam int BALLS  = 3;
    localparam int BALL_W = 2;
    localparam int HOLD   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        btn = 2'b00;
    logic              hit = 1'b0, miss = 1'b0, refr_tick = 1'b0;
    logic              d_inc, d_clr, gra_still, game_over;
    logic [BALL_W-1:0] ball_cnt;
    logic [1:0]        state_o;

    int nchk = 0, nfail = 0;
    int tcnt = 0;
    bit tick_en = 1'b0;
    bit cmp_en  = 1'b0;

    pong_game_ctrl #(.BALLS(BALLS), .BALL_W(BALL_W), .HOLD_TICKS(HOLD)) dut (
        .clk(clk), .reset(reset), .btn(btn), .hit(hit), .miss(miss),
        .refr_tick(refr_tick), .d_inc(d_inc), .d_clr(d_clr), .gra_still(gra_still),
        .ball_cnt(ball_cnt), .state_o(state_o), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Model: game phase, balls left, pending score pulse, ticks seen in pause
    int m_phase = 0, m_balls = BALLS, m_ticks = HOLD;
    bit m_inc = 1'b0;

    always @(posedge clk or posedge reset) begin
        int ph, bl, tk;
        bit done, pr, st;
        if (reset) begin
            m_phase <= 0; m_balls <= BALLS; m_inc <= 1'b0; m_ticks <= HOLD;
        end else begin
            ph = m_phase; bl = m_balls; tk = m_ticks;
            done = (m_ticks >= HOLD - 1);
            pr = (btn != 2'b00);
            st = 1'b0;
            if (ph == 0) begin
                if (pr) begin ph = 1; bl = BALLS - 1; end
            end else if (ph == 1) begin
                if (miss) begin
                    st = 1'b1;
                    if (bl == 0) ph = 3;
                    else begin ph = 2; bl = bl - 1; end
                end
            end else if (ph == 2) begin
                if (done && pr) ph = 1;
            end else begin
                if (done) begin ph = 0; bl = BALLS; end
            end
            if (st) tk = 0;
            else if (refr_tick && tk < HOLD) tk = tk + 1;
            m_inc   <= (m_phase == 1) && hit && !miss;
            m_phase <= ph; m_balls <= bl; m_ticks <= tk;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            nchk++;
            if (state_o !== 2'(m_phase) || ball_cnt !== BALL_W'(m_balls) ||
                d_inc !== m_inc || d_clr !== (m_phase == 0) ||
                gra_still !== (m_phase != 1) || game_over !== (m_phase == 3)) begin
                nfail++;
                $display("FAIL model t=%0t act st=%0d balls=%0d inc=%0b clr=%0b still=%0b over=%0b req st=%0d balls=%0d inc=%0b",
                         $time, state_o, ball_cnt, d_inc, d_clr, gra_still, game_over,
                         m_phase, m_balls, m_inc);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s act=%0d req=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            refr_tick = tick_en && (tcnt == 7);
            tcnt = (tcnt + 1) % 8;
            @(negedge clk); #1;
        end
        refr_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk); #1;
        cmp_en = 1'b1;
        step(2);
        reset = 1'b0;
        step(10);
        check("rst_state", state_o, 0);
        check("rst_dclr", d_clr, 1);
        check("rst_still", gra_still, 1);
        check("rst_balls", ball_cnt, 3);
        check("rst_dinc", d_inc, 0);
        check("rst_over", game_over, 0);

        btn = 2'b01; step(1); btn = 2'b00;
        check("start_state", state_o, 1);
        check("start_balls", ball_cnt, 2);
        check("start_dclr", d_clr, 0);
        check("start_still", gra_still, 0);

        for (int i = 0; i < 3; i++) begin
            hit = 1'b1; step(1); hit = 1'b0;
            check("hit_dinc_hi", d_inc, 1);
            step(1);
            check("hit_dinc_lo", d_inc, 0);
            step(3);
        end
        hit = 1'b1; miss = 1'b1; step(1); hit = 1'b0; miss = 1'b0;
        check("hitmiss_dinc", d_inc, 0);
        check("hitmiss_state", state_o, 2);
        check("hitmiss_balls", ball_cnt, 1);

        // held button: released only once the pause expires
        tick_en = 1'b1; tcnt = 0; btn = 2'b01;
        step(16);
        check("nb_2ticks", state_o, 2);
        step(8);
        check("nb_3ticks", state_o, 2);
        step(1);
        check("nb_resume", state_o, 1);
        btn = 2'b00;

        miss = 1'b1; step(1); miss = 1'b0;
        check("nb2_state", state_o, 2);
        check("nb2_balls", ball_cnt, 0);
        step(40);
        check("nb2_nopress", state_o, 2);
        btn = 2'b01; step(1); btn = 2'b00;
        check("nb2_resume", state_o, 1);

        miss = 1'b1; step(1); miss = 1'b0;
        check("over_state", state_o, 3);
        check("over_flag", game_over, 1);
        check("over_balls", ball_cnt, 0);
        btn = 2'b01; tcnt = 0;
        step(24);
        check("over_hold", state_o, 3);
        step(1);
        btn = 2'b00;
        check("over_end_state", state_o, 0);
        check("over_end_dclr", d_clr, 1);
        check("over_end_balls", ball_cnt, 3);
        step(1);
        check("newgame_idle", state_o, 0);

        tick_en = 1'b0;
        btn = 2'b01; step(1); btn = 2'b00;
        hit = 1'b1; step(1); hit = 1'b0;
        check("pre_rst_dinc", d_inc, 1);
        reset = 1'b1; #1;
        check("rst_mid_dinc", d_inc, 0);
        check("rst_mid_state", state_o, 0);
        check("rst_mid_balls", ball_cnt, 3);
        step(2);
        reset = 1'b0;
        step(2);
        btn = 2'b10; step(1); btn = 2'b00;
        check("restart_state", state_o, 1);
        check("restart_balls", ball_cnt, 2);
        step(2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
